// File: rtl/de_fetch_align_pkg.sv
// Shared constants for the fetch aligner: parcel geometry and instruction size codes.
// Size codes match the encoding of the top two bits of an instruction's first parcel.
package de_fetch_align_pkg;

  localparam int PARCEL_W      = 16;
  localparam int FETCH_PARCELS = 4;

  localparam logic [1:0] ISZ_16 = 2'b00;
  localparam logic [1:0] ISZ_32 = 2'b10;
  localparam logic [1:0] ISZ_64 = 2'b11;

  // Left-justified mask covering the first 'need' parcels of a 64-bit word.
  function automatic logic [63:0] need_mask(input logic [2:0] need);
    logic [63:0] m;
    case (need)
      3'd1:    m = 64'hFFFF_0000_0000_0000;
      3'd2:    m = 64'hFFFF_FFFF_0000_0000;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/de_align_len.sv
// Length decode of an instruction's first parcel: parcel count and size code.
// Combinational; only the top two bits of the parcel matter.
module de_align_len
  import de_fetch_align_pkg::*;
(
  input  logic [1:0] len_bits_i,
  output logic [2:0] need_o,
  output logic [1:0] size_o
);

  always_comb begin
    need_o = 3'd1;
    size_o = ISZ_16;
    if (len_bits_i == 2'b10) begin
      need_o = 3'd2;
      size_o = ISZ_32;
    end else if (len_bits_i == 2'b11) begin
      need_o = 3'd4;
      size_o = ISZ_64;
    end
  end

endmodule

// File: rtl/de_fetch_align.sv
// Splits 64-bit fetch words into left-justified 16/32/64-bit instructions; a word accepted at
// edge N shows its first instruction in cycle N+1; fetch stalls while more than 4 parcels wait.
module de_fetch_align
  import de_fetch_align_pkg::*;
#(
  parameter int PC_WIDTH = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [63:0]         fetch_data_i,
  input  logic                fetch_valid_i,
  output logic                fetch_ready_o,
  input  logic                flush_i,
  input  logic [PC_WIDTH-1:0] flush_pc_i,
  output logic [63:0]         inst_out_o,
  output logic [1:0]          inst_size_o,
  output logic [PC_WIDTH-1:0] inst_pc_o,
  output logic                inst_valid_o,
  input  logic                inst_ready_i
);

  logic [127:0]        buf_q, buf_d, buf_pop;
  logic [3:0]          count_q, count_d, cnt_pop;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]          skip_q, skip_d;

  logic [2:0]  need;
  logic [1:0]  size;
  logic [63:0] word_sh;
  logic        out_live, pop, push;

  de_align_len u_len (
    .len_bits_i (buf_q[127:126]),
    .need_o     (need),
    .size_o     (size)
  );

  assign out_live      = (count_q != 4'd0) && !rst_i;
  assign inst_valid_o  = (count_q >= {1'b0, need}) && !flush_i && !rst_i;
  assign inst_out_o    = out_live ? (buf_q[127:64] & need_mask(need)) : 64'd0;
  assign inst_size_o   = out_live ? size : 2'b00;
  assign inst_pc_o     = out_live ? pc_q : '0;
  assign fetch_ready_o = (count_q <= 4'd4) && !flush_i && !rst_i;

  assign pop  = inst_valid_o && inst_ready_i;
  assign push = fetch_valid_i && fetch_ready_o;

  // Parcels already fetched but before the target PC are dropped off the front of the word.
  assign word_sh = fetch_data_i << (7'(skip_q) * 7'(PARCEL_W));

  always_comb begin
    buf_pop = buf_q;
    cnt_pop = count_q;
    pc_d    = pc_q;
    if (pop) begin
      buf_pop = buf_q << (7'(need) * 7'(PARCEL_W));
      cnt_pop = count_q - {1'b0, need};
      pc_d    = pc_q + PC_WIDTH'({need, 1'b0});
    end
    buf_d   = buf_pop;
    count_d = cnt_pop;
    skip_d  = skip_q;
    // Slots past the live count are zero, so appending is a plain OR after the shift.
    if (push) begin
      buf_d   = buf_pop | ({word_sh, 64'd0} >> (8'(cnt_pop) * 8'(PARCEL_W)));
      count_d = cnt_pop + (4'(FETCH_PARCELS) - {2'b00, skip_q});
      skip_d  = 2'b00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q   <= '0;
      count_q <= '0;
      pc_q    <= '0;
      skip_q  <= '0;
    end else if (flush_i) begin
      buf_q   <= '0;
      count_q <= '0;
      pc_q    <= {flush_pc_i[PC_WIDTH-1:1], 1'b0};
      skip_q  <= flush_pc_i[2:1];
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
    end
  end

endmodule
